seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The master issues operations; the slave (the divider) returns results.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dsr_in;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    // A new request is taken whenever no division is running, including the DONE cycle.
    assign accept    = bus.start && (state != RUN);
    assign last_step = (count_q == CW'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    // The RUN loop only ever sees magnitudes; signs are reapplied on the final edge.
    assign dvd_in    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dsr_in    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign quo_final = q_neg_q ? -quo_step : quo_step;
    assign rem_final = r_neg_q ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_q <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dvd_in    = bus.dividend;
    assign dsr_in    = bus.divisor;
    assign quo_final = quo_step;
    assign rem_final = rem_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE, DONE: begin
                bus.done = (state == DONE);
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Quotient bits shift into the low end of the dividend register as it empties.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        qbit     = ~trial[WIDTH];
        rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            if (bus.divisor == '0) begin
                quotient_q  <= '1;
                remainder_q <= bus.dividend;
                dbz_q       <= 1'b1;
            end else begin
                rem_q   <= '0;
                dvd_q   <= dvd_in;
                dsr_q   <= dsr_in;
                count_q <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            rem_q   <= rem_step;
            dvd_q   <= quo_step;
            count_q <= count_q - CW'(1);
            if (last_step) begin
                quotient_q  <= quo_final;
                remainder_q <= rem_final;
                dbz_q       <= 1'b0;
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): vector table, hand sequences, random vs model.
// Follows SEQ_DIVIDER_SIGNED_EN so the model matches the build under test.
module tb_seq_divider;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Division as defined arithmetically, independent of any shift/subtract schedule.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic dbz);
        int sa;
        int sb;
        dbz = (b == 0);
        if (dbz) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts negedges from the one after the accepting edge until done, bounded.
    task automatic waitDone(input int startCount, output int lat);
        lat = startCount;
        while (!bus.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkResult(input string name, input int lat,
                               input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        checkOutput({name, " latency"}, lat, edbz ? 0 : W);
        checkOutput({name, " quotient"}, int'(bus.quotient), int'(eq));
        checkOutput({name, " remainder"}, int'(bus.remainder), int'(er));
        checkOutput({name, " div_by_zero"}, int'(bus.div_by_zero), int'(edbz));
        checkOutput({name, " busy_at_done"}, int'(bus.busy), 0);
        @(negedge clk);
        checkOutput({name, " done_pulse"}, int'(bus.done), 0);
        checkOutput({name, " quotient_held"}, int'(bus.quotient), int'(eq));
    endtask

    task automatic runModel(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
        int           lat;
        refDiv(a, b, eq, er, edbz);
        applyStimulus(a, b);
        waitDone(0, lat);
        checkResult(name, lat, eq, er, edbz);
    endtask

    initial begin
        int lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic edbz;
        bit sawDone;

        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back('{4'h9, 4'h2, 4'hD, 4'hF, 1'b0});
        vecs.push_back('{4'h8, 4'hF, 4'h8, 4'h0, 1'b0});
        vecs.push_back('{4'h7, 4'hE, 4'hD, 4'h1, 1'b0});
        vecs.push_back('{4'h9, 4'hE, 4'h3, 4'hF, 1'b0});
        vecs.push_back('{4'h8, 4'h3, 4'hE, 4'hE, 1'b0});
        vecs.push_back('{4'h6, 4'h3, 4'h2, 4'h0, 1'b0});
        vecs.push_back('{4'h5, 4'h0, 4'hF, 4'h5, 1'b1});
`else
        vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1, 1'b0});
        vecs.push_back('{4'd9,  4'd0,  4'hF,  4'd9, 1'b1});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0, 1'b0});
        vecs.push_back('{4'd3,  4'd15, 4'd0,  4'd3, 1'b0});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0});
        vecs.push_back('{4'd14, 4'd5,  4'd2,  4'd4, 1'b0});
        vecs.push_back('{4'd8,  4'd3,  4'd2,  4'd2, 1'b0});
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset quotient", int'(bus.quotient), 0);
        checkOutput("reset remainder", int'(bus.remainder), 0);
        checkOutput("reset div_by_zero", int'(bus.div_by_zero), 0);

        // 13/3 with busy observed on every RUN cycle
        refDiv(4'd13, 4'd3, eq, er, edbz);
        applyStimulus(4'd13, 4'd3);
        for (int i = 0; i < W; i++) begin
            checkOutput($sformatf("13/3 busy cycle %0d", i), int'(bus.busy), 1);
            checkOutput($sformatf("13/3 done early %0d", i), int'(bus.done), 0);
            @(negedge clk);
        end
        checkResult("13/3", bus.done ? W : 50, eq, er, edbz);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            waitDone(0, lat);
            checkResult($sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b), lat,
                        vecs[i].q, vecs[i].r, vecs[i].dbz);
        end

        // Start while busy is ignored, operand changes don't matter, then restart in DONE
        refDiv(4'd15, 4'd1, eq, er, edbz);
        applyStimulus(4'd15, 4'd1);
        bus.start    = 1'b1;
        bus.dividend = 4'd2;
        bus.divisor  = 4'd2;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 4'd3;
        bus.divisor  = 4'd0;
        waitDone(1, lat);
        checkOutput("ignored-start latency", lat, W);
        checkOutput("ignored-start quotient", int'(bus.quotient), int'(eq));
        checkOutput("ignored-start remainder", int'(bus.remainder), int'(er));
        refDiv(4'd2, 4'd2, eq, er, edbz);
        bus.start    = 1'b1;
        bus.dividend = 4'd2;
        bus.divisor  = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done-restart done_pulse", int'(bus.done), 0);
        checkOutput("done-restart busy", int'(bus.busy), 1);
        waitDone(0, lat);
        checkResult("done-restart 2/2", lat, eq, er, edbz);

        // Reset mid-operation aborts without a done pulse
        applyStimulus(4'd14, 4'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", int'(bus.busy), 0);
        checkOutput("abort quotient", int'(bus.quotient), 0);
        checkOutput("abort remainder", int'(bus.remainder), 0);
        checkOutput("abort div_by_zero", int'(bus.div_by_zero), 0);
        sawDone = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            if (bus.done) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort no done", int'(sawDone), 0);
        runModel("after-abort 7/7", 4'd7, 4'd7);

        for (int i = 0; i < 40; i++) begin
            runModel($sformatf("rand%0d", i), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
